// File: rtl/kiss_core_hs.sv
// kiss_core_hs -- multi-cycle 9-field-ISA core with valid/ack memory handshakes.
//
// Each instruction walks FETCH -> EXEC -> [MEM] -> FETCH. The instruction fetch and
// the data access both wait for an ack, so either memory may insert wait states.
// All outputs are registered. A one-cycle retire pulse, together with the PC of the
// retired instruction, marks each completed instruction.
//
// Instruction fields, LSB first:
//   src1[RW] src2[RW] dst[RW] imm[IMM_W] m_w r_w op r_src b
//
// Ports:
//   clk, rst_n                 rising-edge clock, async active-low reset
//   imem_req/addr              fetch request and address (= PC)
//   imem_ack/rdata             fetch done; instruction is valid in the ack cycle
//   dmem_req/we/addr/wdata     data request; we=1 store, addr = ALU result, wdata = reg[dst]
//   dmem_ack/rdata             data done; load data is valid in the ack cycle
//   retire/retire_pc           1-cycle pulse per completed instruction, with its PC
module kiss_core_hs #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter int              IMM_W    = 5,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  localparam int             RW       = $clog2(NREGS),
  localparam int             INSN_W   = 3*RW + IMM_W + 5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              retire,
  output logic [XLEN-1:0]   retire_pc
);

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM} state_t;

  state_t            state_q, state_d;
  logic [INSN_W-1:0] ir_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   regs_q [NREGS];

  // Decoded fields of the latched instruction.
  logic [RW-1:0]     src1, src2, dst;
  logic [IMM_W-1:0]  imm;
  logic              m_w, r_w, op, r_src, b;
  assign {b, r_src, op, r_w, m_w, imm, dst, src2, src1} = ir_q;

  logic [XLEN-1:0]   s1, s2, s_dst, imm_sext, alu, w_v, pc_next;
  logic              commit;

  // Register 0 always reads as zero, whatever the array holds.
  assign s1       = (src1 == '0) ? '0 : regs_q[src1];
  assign s2       = (src2 == '0) ? '0 : regs_q[src2];
  assign s_dst    = (dst  == '0) ? '0 : regs_q[dst];
  assign imm_sext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  assign alu      = op ? (s1 + s2 + imm_sext) : (s1 - s2 + imm_sext);

  // Registers and IR do not change while in MEM, so alu is still valid at commit.
  // A store with r_src set is a plain store: the load path is only taken without m_w.
  assign w_v     = (r_src && !m_w) ? dmem_rdata : alu;
  assign pc_next = b ? (pc_q + w_v) : (pc_q + XLEN'(1));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_FETCH: if (imem_req && imem_ack) state_d = ST_EXEC;
      ST_EXEC: begin
        if (m_w || r_src) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_FETCH;
          commit  = 1'b1;
        end
      end
      ST_MEM: begin
        if (dmem_req && dmem_ack) begin
          state_d = ST_FETCH;
          commit  = 1'b1;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= PC_RESET;
      ir_q       <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      retire     <= 1'b0;
      retire_pc  <= '0;
      // NOTE: the register file is architecturally zero after reset, so it is
      // cleared here instead of being left as an unreset RAM.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      retire  <= 1'b0;

      unique case (state_q)
        ST_FETCH: begin
          // Only the first fetch after reset arrives here with req low.
          if (!imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= pc_q;
          end else if (imem_ack) begin
            ir_q     <= imem_rdata;
            imem_req <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (m_w || r_src) begin
            dmem_req   <= 1'b1;
            dmem_we    <= m_w;
            dmem_addr  <= alu;
            dmem_wdata <= s_dst;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
          end
        end
        default: ;
      endcase

      // Commit raises the next fetch request in the same edge, so an ALU-only
      // instruction costs exactly fetch-ack cycle plus one execute cycle.
      if (commit) begin
        if (r_w && dst != '0) regs_q[dst] <= w_v;
        pc_q      <= pc_next;
        imem_req  <= 1'b1;
        imem_addr <= pc_next;
        retire    <= 1'b1;
        retire_pc <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_kiss_core_hs.sv
// Directed bench for kiss_core_hs: reset, ALU, store/load with wait states,
// branches with PC wrap, writes to register 0, and reset during a data access.
// Register contents are observed through the store data port.
module tb_kiss_core_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr;
  logic [24:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        retire;
  logic [31:0] retire_pc;

  int n_vec = 0;
  int n_err = 0;

  kiss_core_hs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .retire     (retire),
    .retire_pc  (retire_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] mk(input logic b, r_src, op, r_w, m_w,
                                     input logic [4:0] imm, dst, src2, src1);
    return {b, r_src, op, r_w, m_w, imm, dst, src2, src1};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one instruction with a zero-wait ack; returns at the negedge in EXEC.
  task automatic do_fetch(input logic [24:0] insn);
    int waited = 0;
    while (imem_req !== 1'b1 && waited < 8) begin
      step();
      waited++;
    end
    n_vec++;
    if (imem_req !== 1'b1) begin n_err++; $display("FAIL fetch_req: imem_req=%b want 1", imem_req); end
    imem_rdata = insn;
    imem_ack   = 1'b1;
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (imem_req !== 1'b0)   begin n_err++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_imem_addr: got %h want 0", imem_addr); end
    n_vec++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin n_err++; $display("FAIL rst_dmem: req=%b we=%b want 0 0", dmem_req, dmem_we); end
    n_vec++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_dmem_bus: addr=%h wdata=%h want 0 0", dmem_addr, dmem_wdata); end
    n_vec++; if (retire !== 1'b0 || retire_pc !== 32'h0) begin n_err++; $display("FAIL rst_retire: %b %h want 0 0", retire, retire_pc); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rel_req_early: got %b want 0", imem_req); end
    @(negedge clk);
    step();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL rel_fetch: req=%b addr=%h want 1 0", imem_req, imem_addr); end
  endtask

  task automatic test_alu();
    // r1 = 0 + 0 + 5
    do_fetch(mk(0, 0, 1, 1, 0, 5'd5, 5'd1, 5'd0, 5'd0));
    n_vec++; if (imem_req !== 1'b0 || retire !== 1'b0) begin n_err++; $display("FAIL alu0_exec: req=%b retire=%b want 0 0", imem_req, retire); end
    step();
    n_vec++; if (retire !== 1'b1 || retire_pc !== 32'h0) begin n_err++; $display("FAIL alu0_retire: %b pc=%h want 1 0", retire, retire_pc); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h1) begin n_err++; $display("FAIL alu0_next: req=%b addr=%h want 1 1", imem_req, imem_addr); end
    // r2 = r1 - r1 + (-1) = FFFFFFFF
    do_fetch(mk(0, 0, 0, 1, 0, 5'b11111, 5'd2, 5'd1, 5'd1));
    n_vec++; if (retire !== 1'b0) begin n_err++; $display("FAIL alu1_pulse: retire=%b want 0", retire); end
    step();
    n_vec++; if (retire !== 1'b1 || retire_pc !== 32'h1) begin n_err++; $display("FAIL alu1_retire: %b pc=%h want 1 1", retire, retire_pc); end
    n_vec++; if (imem_addr !== 32'h2) begin n_err++; $display("FAIL alu1_next: addr=%h want 2", imem_addr); end
  endtask

  task automatic test_mem_wait();
    // Store r1 to address 7 with three wait cycles on dmem_ack.
    do_fetch(mk(0, 0, 1, 0, 1, 5'd7, 5'd1, 5'd0, 5'd0));
    step();
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'd7 || dmem_wdata !== 32'd5 || retire !== 1'b0) begin
        n_err++;
        $display("FAIL st_hold%0d: req=%b we=%b addr=%h wdata=%h retire=%b want 1 1 7 5 0", k, dmem_req, dmem_we, dmem_addr, dmem_wdata, retire);
      end
      if (k == 3) dmem_ack = 1'b1;
      step();
    end
    dmem_ack = 1'b0;
    n_vec++; if (retire !== 1'b1 || retire_pc !== 32'h2) begin n_err++; $display("FAIL st_retire: %b pc=%h want 1 2", retire, retire_pc); end
    n_vec++; if (dmem_req !== 1'b0 || imem_addr !== 32'h3) begin n_err++; $display("FAIL st_after: dreq=%b iaddr=%h want 0 3", dmem_req, imem_addr); end
    // Load r3 from address 7, zero-wait.
    do_fetch(mk(0, 1, 1, 1, 0, 5'd7, 5'd3, 5'd0, 5'd0));
    step();
    n_vec++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'd7) begin n_err++; $display("FAIL ld_req: req=%b we=%b addr=%h want 1 0 7", dmem_req, dmem_we, dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 32'd5;
    step();
    dmem_ack = 1'b0; dmem_rdata = '0;
    n_vec++; if (retire !== 1'b1 || retire_pc !== 32'h3 || imem_addr !== 32'h4) begin n_err++; $display("FAIL ld_retire: %b pc=%h next=%h want 1 3 4", retire, retire_pc, imem_addr); end
    // Store r2 to address 0: shows r2 = FFFFFFFF.
    do_fetch(mk(0, 0, 1, 0, 1, 5'd0, 5'd2, 5'd0, 5'd0));
    step();
    n_vec++; if (dmem_wdata !== 32'hFFFF_FFFF || dmem_addr !== 32'h0) begin n_err++; $display("FAIL st_r2: wdata=%h addr=%h want ffffffff 0", dmem_wdata, dmem_addr); end
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    n_vec++; if (imem_addr !== 32'h5) begin n_err++; $display("FAIL st_r2_next: addr=%h want 5", imem_addr); end
  endtask

  task automatic test_branch();
    // PC 5: branch by -2 -> 3
    do_fetch(mk(1, 0, 1, 0, 0, 5'b11110, 5'd0, 5'd0, 5'd0));
    step();
    n_vec++; if (retire !== 1'b1 || retire_pc !== 32'h5 || imem_addr !== 32'h3) begin n_err++; $display("FAIL br_back2: %b pc=%h next=%h want 1 5 3", retire, retire_pc, imem_addr); end
    // PC 3: store r3 to address 1 -> shows load result r3 = 5
    do_fetch(mk(0, 0, 1, 0, 1, 5'd1, 5'd3, 5'd0, 5'd0));
    step();
    n_vec++; if (dmem_wdata !== 32'd5 || dmem_addr !== 32'd1) begin n_err++; $display("FAIL st_r3: wdata=%h addr=%h want 5 1", dmem_wdata, dmem_addr); end
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    // PC 4: branch by -4 -> 0
    do_fetch(mk(1, 0, 1, 0, 0, 5'b11100, 5'd0, 5'd0, 5'd0));
    step();
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL br_to0: addr=%h want 0", imem_addr); end
    // PC 0: branch by -1 -> FFFFFFFF
    do_fetch(mk(1, 0, 1, 0, 0, 5'b11111, 5'd0, 5'd0, 5'd0));
    step();
    n_vec++; if (imem_addr !== 32'hFFFF_FFFF || retire_pc !== 32'h0) begin n_err++; $display("FAIL br_wrap: addr=%h pc=%h want ffffffff 0", imem_addr, retire_pc); end
  endtask

  task automatic test_reg0();
    // PC FFFFFFFF: write 9 to r0 (dropped); PC+1 wraps to 0.
    do_fetch(mk(0, 0, 1, 1, 0, 5'd9, 5'd0, 5'd0, 5'd0));
    step();
    n_vec++; if (retire !== 1'b1 || retire_pc !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL r0_retire: %b pc=%h want 1 ffffffff", retire, retire_pc); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL pc_wrap: addr=%h want 0", imem_addr); end
    // PC 0: store r0 to address 3 -> wdata must be 0. Left waiting for test_reset_mid.
    do_fetch(mk(0, 0, 1, 0, 1, 5'd3, 5'd0, 5'd0, 5'd0));
    step();
    n_vec++; if (dmem_req !== 1'b1 || dmem_wdata !== 32'h0 || dmem_addr !== 32'd3) begin n_err++; $display("FAIL st_r0: req=%b wdata=%h addr=%h want 1 0 3", dmem_req, dmem_wdata, dmem_addr); end
  endtask

  task automatic test_reset_mid();
    step();
    n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL mid_wait: dmem_req=%b want 1", dmem_req); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL mid_drop: dreq=%b ireq=%b want 0 0", dmem_req, imem_req); end
    dmem_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_vec++; if (retire !== 1'b0) begin n_err++; $display("FAIL mid_retire%0d: got %b want 0", k, retire); end
    end
    dmem_ack = 1'b0;
    rst_n = 1'b1;
    step();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || retire !== 1'b0) begin n_err++; $display("FAIL mid_refetch: req=%b addr=%h retire=%b want 1 0 0", imem_req, imem_addr, retire); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch();
    test_reg0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
